// File: rtl/lcd_msg_arbiter_pkg.sv
// Shared definitions for the LCD message arbiter.
//   - state_t    : arbiter FSM state encoding
//   - TIME_W_DEF : default width of the reaction-time field (ms, 0..999)
//   - clog2_f    : constant-function ceil(log2(v)), minimum result 1
package lcd_msg_arbiter_pkg;

    typedef enum logic [2:0] {
        S_Idle    = 3'd0,
        S_Issue   = 3'd1,
        S_Release = 3'd2,
        S_Hold    = 3'd3,
        S_Done    = 3'd4
    } state_t;

    localparam int TIME_W_DEF = 10;

    function automatic int clog2_f(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/lcd_msg_arbiter_hold_counter.sv
// lcd_hold_counter: loadable down-counter with terminal-count flag.
// Shared by the arbiter for both the LCD ack timeout and the display hold.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_load         : load i_load_val (has priority over counting)
//   i_load_val     : value to load; terminal count is reached after
//                    i_load_val further enabled cycles
//   i_en           : decrement enable (stops at zero)
//   o_tc           : count is zero
module lcd_hold_counter
    import lcd_msg_arbiter_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/lcd_msg_arbiter.sv
// lcd_msg_arbiter: shares one LCD message port between two requesters
// (0 = reaction-timer game FSM, 1 = best-time/status tracker).
// Latches the granted message, runs the LCDUpdate/LCDAck four-phase
// handshake, holds the message on screen for HOLD_CYCLES, then acks the
// requester. Ties are broken round-robin; an unanswered handshake is
// abandoned after ACK_TIMEOUT cycles with a one-cycle o_timeout pulse.
// Ports:
//   i_clk, i_rst                    : clock, synchronous active-high reset
//   i_req0/1                        : request levels, held until o_ack0/1
//   i_cheat0/1, i_slow0/1, i_wait0/1: message flags, valid while request high
//   i_time0/1                       : reaction time, valid while request high
//   o_ack0/1                        : service done, high until request drops
//   o_cheat, o_slow, o_wait,
//   o_reaction_time                 : latched message to the LCD block
//   o_lcd_update, i_lcd_ack         : handshake with the LCD block
//   o_busy                          : high whenever not idle
//   o_timeout                       : one-cycle pulse on handshake abort
//
// state     | meaning
// S_Idle    | waiting for a request; grants on the edge one is seen
// S_Issue   | LCDUpdate high, waiting for LCDAck (with timeout)
// S_Release | LCDUpdate low, waiting for LCDAck to drop
// S_Hold    | message held on screen for HOLD_CYCLES
// S_Done    | granted Ack high, waiting for its request to drop
module lcd_msg_arbiter
    import lcd_msg_arbiter_pkg::*;
#(
    parameter int TIME_W      = TIME_W_DEF,
    parameter int HOLD_CYCLES = 50000000,
    parameter int ACK_TIMEOUT = 1000000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_cheat0,
    input  logic              i_slow0,
    input  logic              i_wait0,
    input  logic [TIME_W-1:0] i_time0,
    output logic              o_ack0,
    input  logic              i_req1,
    input  logic              i_cheat1,
    input  logic              i_slow1,
    input  logic              i_wait1,
    input  logic [TIME_W-1:0] i_time1,
    output logic              o_ack1,
    output logic              o_cheat,
    output logic              o_slow,
    output logic              o_wait,
    output logic [TIME_W-1:0] o_reaction_time,
    output logic              o_lcd_update,
    input  logic              i_lcd_ack,
    output logic              o_busy,
    output logic              o_timeout
);

    localparam int CNT_MAX = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
    localparam int CNT_W   = clog2_f(CNT_MAX);
    localparam logic [CNT_W-1:0] LD_ACK  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LD_HOLD = CNT_W'(HOLD_CYCLES - 1);

    state_t r_state;
    state_t w_state_nxt;

    // r_last doubles as the current grant while a message is in service.
    logic r_last;
    logic w_any_req;
    logic w_sel;
    logic w_req_gnt;

    logic              r_cheat, r_slow, r_wait, r_upd, r_ack0, r_ack1, r_busy, r_timeout;
    logic [TIME_W-1:0] r_time;
    logic              w_cheat_nxt, w_slow_nxt, w_wait_nxt, w_upd_nxt;
    logic              w_ack0_nxt, w_ack1_nxt, w_timeout_nxt, w_last_nxt;
    logic [TIME_W-1:0] w_time_nxt;

    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_load_val;
    logic             w_cnt_en;
    logic             w_cnt_tc;

    assign w_any_req = i_req0 | i_req1;
    // Both requesting: the one not served last wins; otherwise whoever asks.
    assign w_sel     = (i_req0 & i_req1) ? ~r_last : i_req1;
    assign w_req_gnt = r_last ? i_req1 : i_req0;

    lcd_hold_counter #(
        .CNT_W(CNT_W)
    ) u_hold_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_en       (w_cnt_en),
        .o_tc       (w_cnt_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_Idle;
            r_last    <= 1'b1;
            r_cheat   <= 1'b0;
            r_slow    <= 1'b0;
            r_wait    <= 1'b0;
            r_time    <= '0;
            r_upd     <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_cheat   <= w_cheat_nxt;
            r_slow    <= w_slow_nxt;
            r_wait    <= w_wait_nxt;
            r_time    <= w_time_nxt;
            r_upd     <= w_upd_nxt;
            r_ack0    <= w_ack0_nxt;
            r_ack1    <= w_ack1_nxt;
            r_busy    <= (w_state_nxt != S_Idle);
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_Idle:    if (w_any_req) w_state_nxt = S_Issue;
            S_Issue: begin
                if (i_lcd_ack)     w_state_nxt = S_Release;
                else if (w_cnt_tc) w_state_nxt = S_Done;
            end
            S_Release: if (!i_lcd_ack) w_state_nxt = S_Hold;
            S_Hold:    if (w_cnt_tc)   w_state_nxt = S_Done;
            S_Done:    if (!w_req_gnt) w_state_nxt = S_Idle;
            default:   w_state_nxt = S_Idle;
        endcase
    end

    always_comb begin
        w_cnt_load     = 1'b0;
        w_cnt_load_val = LD_ACK;
        w_cnt_en       = 1'b0;
        w_last_nxt     = r_last;
        w_cheat_nxt    = r_cheat;
        w_slow_nxt     = r_slow;
        w_wait_nxt     = r_wait;
        w_time_nxt     = r_time;
        w_upd_nxt      = r_upd;
        w_ack0_nxt     = r_ack0;
        w_ack1_nxt     = r_ack1;
        w_timeout_nxt  = 1'b0;
        case (r_state)
            S_Idle: begin
                if (w_any_req) begin
                    w_last_nxt  = w_sel;
                    w_cheat_nxt = w_sel ? i_cheat1 : i_cheat0;
                    w_slow_nxt  = w_sel ? i_slow1  : i_slow0;
                    w_wait_nxt  = w_sel ? i_wait1  : i_wait0;
                    w_time_nxt  = w_sel ? i_time1  : i_time0;
                    w_upd_nxt   = 1'b1;
                    w_cnt_load  = 1'b1;
                end
            end
            S_Issue: begin
                w_cnt_en = 1'b1;
                if (i_lcd_ack) begin
                    w_upd_nxt = 1'b0;
                end else if (w_cnt_tc) begin
                    // Abort, but still ack so the requester is not left hanging.
                    w_upd_nxt     = 1'b0;
                    w_timeout_nxt = 1'b1;
                    w_ack0_nxt    = ~r_last;
                    w_ack1_nxt    = r_last;
                end
            end
            S_Release: begin
                if (!i_lcd_ack) begin
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = LD_HOLD;
                end
            end
            S_Hold: begin
                w_cnt_en = 1'b1;
                if (w_cnt_tc) begin
                    w_ack0_nxt = ~r_last;
                    w_ack1_nxt = r_last;
                end
            end
            S_Done: begin
                if (!w_req_gnt) begin
                    w_ack0_nxt = 1'b0;
                    w_ack1_nxt = 1'b0;
                end
            end
            default: begin
                w_upd_nxt  = 1'b0;
                w_ack0_nxt = 1'b0;
                w_ack1_nxt = 1'b0;
            end
        endcase
    end

    assign o_cheat         = r_cheat;
    assign o_slow          = r_slow;
    assign o_wait          = r_wait;
    assign o_reaction_time = r_time;
    assign o_lcd_update    = r_upd;
    assign o_ack0          = r_ack0;
    assign o_ack1          = r_ack1;
    assign o_busy          = r_busy;
    assign o_timeout       = r_timeout;

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
module tb_lcd_msg_arbiter;

    localparam int TIME_W = 10;
    localparam int HOLD   = 4;
    localparam int ACKTO  = 8;

    logic clk = 1'b0;
    logic rst;
    logic req0, cheat0, slow0, wait0;
    logic [TIME_W-1:0] time0;
    logic req1, cheat1, slow1, wait1;
    logic [TIME_W-1:0] time1;
    logic o_ack0, o_ack1, o_cheat, o_slow, o_wait, o_lcd_update, o_busy, o_timeout;
    logic [TIME_W-1:0] o_reaction_time;
    logic lcd_ack;

    int n_checks = 0;
    int n_err    = 0;
    int m_last   = 1;
    bit lcd_on   = 1'b1;
    int lcd_cnt;

    always #5 clk = ~clk;

    lcd_msg_arbiter #(
        .TIME_W(TIME_W), .HOLD_CYCLES(HOLD), .ACK_TIMEOUT(ACKTO)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0(req0), .i_cheat0(cheat0), .i_slow0(slow0), .i_wait0(wait0),
        .i_time0(time0), .o_ack0(o_ack0),
        .i_req1(req1), .i_cheat1(cheat1), .i_slow1(slow1), .i_wait1(wait1),
        .i_time1(time1), .o_ack1(o_ack1),
        .o_cheat(o_cheat), .o_slow(o_slow), .o_wait(o_wait),
        .o_reaction_time(o_reaction_time), .o_lcd_update(o_lcd_update),
        .i_lcd_ack(lcd_ack), .o_busy(o_busy), .o_timeout(o_timeout)
    );

    // LCD block: raises LCDAck 3 cycles after LCDUpdate rises, drops it
    // 1 cycle after LCDUpdate falls; with lcd_on=0 it never answers.
    always @(posedge clk) begin
        if (rst) begin
            lcd_ack <= 1'b0;
            lcd_cnt <= 0;
        end else if (lcd_ack) begin
            if (!o_lcd_update) lcd_ack <= 1'b0;
            lcd_cnt <= 0;
        end else if (o_lcd_update && lcd_on) begin
            if (lcd_cnt == 2) lcd_ack <= 1'b1;
            lcd_cnt <= lcd_cnt + 1;
        end else begin
            lcd_cnt <= 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] mk(input logic c, input logic s, input logic w,
                                       input logic [9:0] t);
        return {c, s, w, t};
    endfunction

    // Reference arbitration: lone requester wins; on a tie the one not
    // served last wins.
    function automatic int pick(input logic r0, input logic r1);
        int w;
        if (r0 && r1) w = (m_last == 0) ? 1 : 0;
        else          w = r1 ? 1 : 0;
        m_last = w;
        return w;
    endfunction

    function automatic logic sig(input int which);
        case (which)
            0:       return o_lcd_update;
            1:       return lcd_ack;
            2:       return o_ack0;
            3:       return o_ack1;
            default: return o_timeout;
        endcase
    endfunction

    function automatic logic [31:0] msg_out();
        return 32'({o_cheat, o_slow, o_wait, o_reaction_time});
    endfunction

    function automatic logic [31:0] all_out();
        return 32'({o_ack0, o_ack1, o_cheat, o_slow, o_wait, o_reaction_time,
                    o_lcd_update, o_busy, o_timeout});
    endfunction

    task automatic wait_sig(input string tag, input int which, input logic val,
                            input int budget, output int n);
        n = 0;
        while (sig(which) !== val && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(sig(which)), 32'(val));
    endtask

    task automatic set_req(input int r, input logic v, input logic [12:0] m);
        if (r == 0) begin
            req0 = v;
            {cheat0, slow0, wait0, time0} = m;
        end else begin
            req1 = v;
            {cheat1, slow1, wait1, time1} = m;
        end
    endtask

    // Follows one granted message from LCDUpdate rise to the requester's Ack.
    task automatic serve(input int g, input logic [12:0] m, input bit acks);
        int n;
        wait_sig("upd_rise", 0, 1'b1, 20, n);
        chk("busy_issue", 32'(o_busy), 32'd1);
        chk("msg_issue", msg_out(), 32'(m));
        chk("acks_issue", 32'({o_ack0, o_ack1}), 32'd0);
        if (acks) begin
            wait_sig("lcd_ack_rise", 1, 1'b1, 10, n);
            tick();
            chk("upd_fall", 32'(o_lcd_update), 32'd0);
            wait_sig("lcd_ack_fall", 1, 1'b0, 10, n);
            // One edge to leave S_Release, then HOLD cycles of S_Hold.
            wait_sig("ack_rise", 2 + g, 1'b1, 20, n);
            chk("hold_len", 32'(n), 32'(HOLD + 1));
            chk("no_timeout", 32'(o_timeout), 32'd0);
        end else begin
            repeat (ACKTO - 1) tick();
            chk("no_early_timeout", 32'({o_timeout, o_lcd_update, sig(2 + g)}), 32'b010);
            tick();
            chk("timeout_state", 32'({o_timeout, o_lcd_update, sig(2 + g)}), 32'b101);
        end
        chk("msg_stable", msg_out(), 32'(m));
        chk("other_ack", 32'(sig(3 - g)), 32'd0);
        chk("busy_done", 32'(o_busy), 32'd1);
    endtask

    task automatic release_req(input int g);
        if (g == 0) req0 = 1'b0; else req1 = 1'b0;
        tick();
        chk("ack_drop", 32'({o_ack0, o_ack1}), 32'd0);
        chk("busy_idle", 32'(o_busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        m_last = 1;
    endtask

    initial begin
        logic [12:0] m0, m1;
        int g, n, r;
        bit acks;

        rst = 1'b1;
        set_req(0, 1'b0, 13'd0);
        set_req(1, 1'b0, 13'd0);
        repeat (3) tick();
        chk("reset_outputs", all_out(), 32'd0);
        rst = 1'b0;
        m_last = 1;
        tick();
        chk("idle_outputs", all_out(), 32'd0);

        // Single request
        m0 = mk(0, 0, 0, 10'd347);
        set_req(0, 1'b1, m0);
        g = pick(1'b1, 1'b0);
        serve(g, m0, 1'b1);
        release_req(0);

        // Simultaneous requests from reset, twice: order alternates
        do_reset();
        for (int k = 0; k < 2; k++) begin
            m0 = mk(1, 0, 0, 10'(100 + k));
            m1 = mk(0, 1, 0, 10'(200 + k));
            set_req(0, 1'b1, m0);
            set_req(1, 1'b1, m1);
            g = pick(1'b1, 1'b1);
            serve(g, (g == 0) ? m0 : m1, 1'b1);
            release_req(g);
            g = pick(g == 1, g == 0);
            serve(g, (g == 0) ? m0 : m1, 1'b1);
            release_req(g);
        end

        // Contention: after requester 1, both ask -> 0; both again -> 1
        for (int k = 0; k < 2; k++) begin
            m0 = mk(0, 0, 1, 10'(300 + k));
            m1 = mk(1, 1, 1, 10'(400 + k));
            set_req(0, 1'b1, m0);
            set_req(1, 1'b1, m1);
            g = pick(1'b1, 1'b1);
            serve(g, (g == 0) ? m0 : m1, 1'b1);
            req0 = 1'b0;
            req1 = 1'b0;
            tick();
            chk("both_drop_idle", 32'({o_busy, o_ack0, o_ack1}), 32'd0);
        end

        // Timeout: LCD never answers
        lcd_on = 1'b0;
        m0 = mk(0, 1, 0, 10'd999);
        set_req(0, 1'b1, m0);
        g = pick(1'b1, 1'b0);
        serve(g, m0, 1'b0);
        tick();
        chk("timeout_one_cycle", 32'({o_timeout, o_ack0}), 32'b01);
        release_req(0);
        lcd_on = 1'b1;

        // Reset during S_Hold, request still high: re-granted afterwards
        m0 = mk(0, 0, 0, 10'd123);
        set_req(0, 1'b1, m0);
        g = pick(1'b1, 1'b0);
        wait_sig("rh_upd_rise", 0, 1'b1, 20, n);
        wait_sig("rh_lcd_ack_rise", 1, 1'b1, 10, n);
        wait_sig("rh_lcd_ack_fall", 1, 1'b0, 10, n);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("reset_mid_hold", all_out(), 32'd0);
        rst = 1'b0;
        m_last = 1;
        g = pick(1'b1, 1'b0);
        serve(g, m0, 1'b1);
        release_req(0);

        // Requester 1 pulses for a single cycle and is still served
        m1 = mk(1, 0, 1, 10'd42);
        set_req(1, 1'b1, m1);
        g = pick(1'b0, 1'b1);
        tick();
        req1 = 1'b0;
        serve(g, m1, 1'b1);
        tick();
        chk("early_drop_ack1", 32'({o_ack1, o_busy}), 32'd0);

        // Randomized traffic
        for (int k = 0; k < 30; k++) begin
            r    = $urandom_range(1, 3);
            acks = ($urandom_range(0, 4) != 0);
            m0   = mk(1'($urandom), 1'($urandom), 1'($urandom), 10'($urandom_range(0, 999)));
            m1   = mk(1'($urandom), 1'($urandom), 1'($urandom), 10'($urandom_range(0, 999)));
            lcd_on = acks;
            set_req(0, r[0], m0);
            set_req(1, r[1], m1);
            g = pick(r[0], r[1]);
            serve(g, (g == 0) ? m0 : m1, acks);
            req0 = 1'b0;
            req1 = 1'b0;
            tick();
            chk("rand_idle", 32'({o_busy, o_ack0, o_ack1, o_timeout}), 32'd0);
        end
        lcd_on = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
